// File: rtl/rsa_bytes_to_words_if.sv
// Handshake/bus bundle between the byte FIFO, the unpacker and the RSA core.
interface rsa_bytes_to_words_if;
  logic [7:0]  data_in;
  logic        rdreq_in;
  logic [31:0] key;
  logic [31:0] mod;
  logic [31:0] plaintext;
  logic        rdreq_out;
  logic        empty;
  logic        done;

  modport master (
    output data_in, rdreq_in,
    input  key, mod, plaintext, rdreq_out, empty, done
  );

  modport slave (
    input  data_in, rdreq_in,
    output key, mod, plaintext, rdreq_out, empty, done
  );
endinterface

// File: rtl/rsa_bytes_to_words.sv
// Pops 12 bytes from a non-show-ahead FIFO and presents key/mod/plaintext words.
// Define LSB_FIRST_EN to place the first byte of each word in bits [7:0].
module rsa_bytes_to_words #(
  parameter int READ_LATENCY = 1,
  parameter int NUM_BYTES    = 12
) (
  input logic                  clock,
  input logic                  reset,
  rsa_bytes_to_words_if.slave  bus
);
  localparam int SR_W = NUM_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [3:0]      count;
  logic [2:0]      wcnt;
  logic [SR_W-1:0] shift_reg;
  logic [SR_W-1:0] shift_nxt;

  assign shift_nxt = {shift_reg[SR_W-9:0], bus.data_in};

  function automatic logic [31:0] word_order(input logic [31:0] w);
`ifdef LSB_FIRST_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      count         <= '0;
      wcnt          <= '0;
      shift_reg     <= '0;
      bus.rdreq_out <= 1'b0;
      bus.done      <= 1'b0;
      bus.empty     <= 1'b1;
      bus.key       <= '0;
      bus.mod       <= '0;
      bus.plaintext <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.rdreq_in) begin
          state         <= S_REQ;
          bus.rdreq_out <= 1'b1;
          bus.empty     <= 1'b0;
          count         <= '0;
        end
        S_REQ: begin
          state         <= S_WAIT;
          bus.rdreq_out <= 1'b0;
          wcnt          <= '0;
        end
        S_WAIT: begin
          if (wcnt == 3'(READ_LATENCY - 1)) begin
            shift_reg <= shift_nxt;
            count     <= count + 4'd1;
            // Load from the next-state shift value so the last byte lands with done.
            if (count == 4'(NUM_BYTES - 1)) begin
              bus.key       <= word_order(shift_nxt[95:64]);
              bus.mod       <= word_order(shift_nxt[63:32]);
              bus.plaintext <= word_order(shift_nxt[31:0]);
              bus.done      <= 1'b1;
              state         <= S_DONE;
            end else begin
              bus.rdreq_out <= 1'b1;
              state         <= S_REQ;
            end
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        S_DONE: if (bus.rdreq_in) begin
          // Old words stay visible until the new set loads.
          state         <= S_REQ;
          bus.rdreq_out <= 1'b1;
          bus.done      <= 1'b0;
          count         <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_bytes_to_words.sv
// Directed/random bench for rsa_bytes_to_words with a queue-based FIFO and word model.
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s: got %0h want %0h", tag, obs, exp); end end

module tb_rsa_bytes_to_words;
  localparam int RL = 1;
  localparam int P  = 1 + RL;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   e0    = 0;
  logic [7:0] fifo[$];
  int   pulses[$];
  logic [7:0] cur[12];

  rsa_bytes_to_words_if bus();

  rsa_bytes_to_words #(.READ_LATENCY(RL), .NUM_BYTES(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // FIFO model: q updates one cycle after a sampled read request
  always @(posedge clock) begin
    if (bus.rdreq_out) begin
      if (fifo.size() > 0) bus.data_in <= fifo.pop_front();
      else                 bus.data_in <= 8'h00;
    end
  end

  always @(posedge clock) begin
    if (bus.rdreq_out) pulses.push_back(cyc);
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef LSB_FIRST_EN
      r = r | (32'(cur[4*w+i]) << (8*i));
`else
      r = (r << 8) | 32'(cur[4*w+i]);
`endif
    end
    return r;
  endfunction

  task automatic load(input int mode);
    fifo.delete();
    for (int i = 0; i < 12; i++) begin
      cur[i] = (mode == 0) ? 8'hFF : 8'($urandom);
      fifo.push_back(cur[i]);
    end
  endtask

  task automatic start(input bit hold);
    pulses.delete();
    bus.rdreq_in = 1'b1;
    @(posedge clock); #1;
    e0 = cyc;
    if (!hold) bus.rdreq_in = 1'b0;
  endtask

  task automatic finish_txn(input string tag);
    int n = 0;
    int sp_bad = 0;
    while (!bus.done && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    bus.rdreq_in = 1'b0;
    `CHK({tag, "_latency"}, cyc - e0, 24)
    `CHK({tag, "_pulses"}, pulses.size(), 12)
    foreach (pulses[k]) if (pulses[k] != e0 + P*k) sp_bad++;
    `CHK({tag, "_spacing"}, sp_bad, 0)
    `CHK({tag, "_key"}, bus.key, exp_word(0))
    `CHK({tag, "_mod"}, bus.mod, exp_word(1))
    `CHK({tag, "_pt"}, bus.plaintext, exp_word(2))
    `CHK({tag, "_done"}, bus.done, 1'b1)
    `CHK({tag, "_empty"}, bus.empty, 1'b0)
  endtask

  initial begin
    logic [7:0] fixed[12] = '{8'd3, 8'd6, 8'd32, 8'd14, 8'd25, 8'd12,
                              8'd54, 8'd66, 8'd33, 8'd38, 8'd71, 8'd4};
    logic [31:0] old_key, old_mod, old_pt;
    bus.rdreq_in = 1'b0;
    bus.data_in  = 8'h00;
    #20 reset = 1'b1;
    #1;
    `CHK("rst_key", bus.key, 32'h0)
    `CHK("rst_mod", bus.mod, 32'h0)
    `CHK("rst_pt", bus.plaintext, 32'h0)
    `CHK("rst_done", bus.done, 1'b0)
    `CHK("rst_empty", bus.empty, 1'b1)
    `CHK("rst_rdreq", bus.rdreq_out, 1'b0)
    @(posedge clock); #1;

    // Fixed spec vector, single-cycle request
    fifo.delete();
    for (int i = 0; i < 12; i++) begin cur[i] = fixed[i]; fifo.push_back(fixed[i]); end
    start(1'b0);
    `CHK("t1_empty_req", bus.empty, 1'b0)
    finish_txn("t1");
`ifdef LSB_FIRST_EN
    `CHK("t1_key_lit", bus.key, 32'h0E200603)
    `CHK("t1_mod_lit", bus.mod, 32'h42360C19)
    `CHK("t1_pt_lit", bus.plaintext, 32'h04472621)
`else
    `CHK("t1_key_lit", bus.key, 32'h0306200E)
    `CHK("t1_mod_lit", bus.mod, 32'h190C3642)
    `CHK("t1_pt_lit", bus.plaintext, 32'h21264704)
`endif
    repeat (3) @(posedge clock); #1;

    // Random bytes, request held through the whole transaction
    load(1);
    start(1'b1);
    finish_txn("t2");
    repeat (6) @(posedge clock); #1;
    `CHK("t2_no_extra", pulses.size(), 12)
    `CHK("t2_hold_key", bus.key, exp_word(0))
    `CHK("t2_hold_done", bus.done, 1'b1)

    // Reset after the 5th byte is captured
    load(1);
    start(1'b0);
    repeat (10) @(posedge clock); #1;
    reset = 1'b0;
    #1;
    `CHK("t3_pulses", pulses.size(), 5)
    `CHK("t3_key", bus.key, 32'h0)
    `CHK("t3_mod", bus.mod, 32'h0)
    `CHK("t3_pt", bus.plaintext, 32'h0)
    `CHK("t3_done", bus.done, 1'b0)
    `CHK("t3_empty", bus.empty, 1'b1)
    `CHK("t3_rdreq", bus.rdreq_out, 1'b0)
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    `CHK("t3_idle_rdreq", bus.rdreq_out, 1'b0)
    load(1);
    start(1'b0);
    finish_txn("t3b");

    // From DONE, refill with 0xFF; old words held while loading
    old_key = bus.key; old_mod = bus.mod; old_pt = bus.plaintext;
    load(0);
    start(1'b0);
    `CHK("t4_done_drop", bus.done, 1'b0)
    repeat (5) @(posedge clock); #1;
    `CHK("t4_old_key", bus.key, old_key)
    `CHK("t4_old_mod", bus.mod, old_mod)
    `CHK("t4_old_pt", bus.plaintext, old_pt)
    finish_txn("t4");
    `CHK("t4_ff_key", bus.key, 32'hFFFFFFFF)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_bytes_to_words.md
Name: rsa_bytes_to_words

Overview:
- Byte-to-word unpacker sitting between the RFID byte FIFO (8-bit, show-ahead off, 1-cycle read latency) and the RSA core.
- On a start request it pops 12 bytes from the FIFO and assembles three 32-bit words: key, modulus, plaintext.
- Results are held stable for the RSA engine, which is started by `done`.

Parameters:
- READ_LATENCY, 1, cycles from a `rdreq_out` cycle until FIFO `q` (`data_in`) is valid; legal 1..4.
- NUM_BYTES, 12, bytes consumed per transaction (fixed 3 words x 4 bytes; other values unsupported).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  FIFO read data (q).
- rdreq_in  in  1  start request; sampled high for one or more cycles while idle.
- key  out  32  word 0 (bytes 0..3).
- mod  out  32  word 1 (bytes 4..7).
- plaintext  out  32  word 2 (bytes 8..11).
- rdreq_out  out  1  FIFO read request, one-cycle pulse per byte.
- empty  out  1  high when idle and no partial data is held.
- done  out  1  high when key/mod/plaintext are valid.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - rdreq_out=0, done=0, empty=1; key/mod/plaintext=0.
  - Byte counter and 96-bit shift register cleared.
  - Reset mid-transaction aborts it; there is no resume.
- States:
  - IDLE: wait for rdreq_in=1 at an edge (call it E0), then go to REQ.
  - REQ: rdreq_out=1 for exactly this one cycle. Go to WAIT.
  - WAIT: lasts READ_LATENCY cycles, rdreq_out=0. At the edge ending the last WAIT cycle, capture the byte: shift_reg <= {shift_reg[87:0], data_in} and increment the count.
    - If count < 12, go to REQ.
    - Else load outputs and go to DONE.
  - DONE: done=1 is a level, held. Another rdreq_in returns to REQ: clear the count and done, keep old key/mod/plaintext until the new load completes.
- Timing, with P = 1 + READ_LATENCY:
  - Byte k (k=0..11) has rdreq_out high in the cycle after edge E0 + P·k.
  - The byte is captured at edge E0 + P·(k+1).
  - With READ_LATENCY=1: 12 rdreq_out pulses spaced 2 cycles apart; outputs load and done rises at E0+24.
- Output load (default byte order, first byte = MSB):
  - key = shift_reg[95:64]
  - mod = shift_reg[63:32]
  - plaintext = shift_reg[31:0]
  - All three load on the same edge that done rises. Outputs never show partial words.
- empty = 1 in IDLE and after reset. 0 from the first REQ until the next reset. Stays 0 in DONE.
- rdreq_in while in REQ/WAIT is ignored. No queuing.
- FIFO underflow is not detected. The upstream must have ≥12 bytes in the FIFO before asserting rdreq_in; otherwise the captured data is undefined but the FSM still completes.
- rdreq_out is registered (glitch-free) and never high in IDLE or DONE.

Optional Feature:
- Macro LSB_FIRST_EN.
- Defined: bytes within each word are little-endian; the first byte of each group of 4 lands in bits [7:0].
  - e.g. bytes 3,6,32,14 -> key=0x0E200603.
- Undefined (default): big-endian, first byte in bits [31:24].
  - e.g. same bytes -> key=0x0306200E.
- Word order (key, mod, plaintext) is unchanged in both modes.

Test Plan:
- Reset low 20ns then high -> key/mod/plaintext=0, done=0, empty=1, rdreq_out=0.
- FIFO preloaded with 3,6,32,14,25,12,54,66,33,38,71,4; pulse rdreq_in for 1 cycle -> exactly 12 rdreq_out pulses, 2 cycles apart. done high at E0+24 with key=0x0306200E, mod=0x190C3642, plaintext=0x21264704. empty=0.
- Same data with LSB_FIRST_EN -> key=0x0E200603, mod=0x42360C19, plaintext=0x04472621.
- Hold rdreq_in high through the whole transaction -> still exactly 12 pulses. The outputs are unchanged by the extra rdreq_in cycles. A second transaction starts only from DONE.
- Assert reset after the 5th byte -> immediate return to IDLE with all outputs 0 and rdreq_out=0. A fresh 12-byte load then completes correctly.
- From DONE, refill with 12 bytes of 0xFF and pulse rdreq_in -> done drops and the old values are held. After 24 cycles key=mod=plaintext=0xFFFFFFFF and done=1.
